// File: rtl/acc_alu_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// acc_alu_sequencer_pkg
//   Shared constants for the accumulator ALU sequencer:
//     - opcode encodings presented on req_op
//     - ALU select codes driven on alu_s
//     - FSM state encoding
//     - compare result words returned by the ALU and the flag patterns
//       they decode into ({lt,eq,gt})
// ---------------------------------------------------------------------------
package acc_alu_sequencer_pkg;

  // Request opcodes
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SLL  = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  // ALU select codes
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_SLL = 2'd2;
  localparam logic [1:0] ALU_CMP = 2'd3;

  // Compare result words produced by the ALU (unsigned a vs b)
  localparam logic [15:0] CMP_LT = 16'hFFFF;
  localparam logic [15:0] CMP_EQ = 16'h0000;
  localparam logic [15:0] CMP_GT = 16'h0001;

  // Flag patterns {lt,eq,gt}
  localparam logic [2:0] FLAG_LT   = 3'b100;
  localparam logic [2:0] FLAG_EQ   = 3'b010;
  localparam logic [2:0] FLAG_GT   = 3'b001;
  localparam logic [2:0] FLAG_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Ops that take one cycle through the external ALU
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLL) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/acc_alu_sequencer_mul_step.sv
// ---------------------------------------------------------------------------
// acc_mul_step
//   Shift-add multiplier state for the sequencer's MUL op. The adder itself
//   is the shared external ALU; this block only holds the operands, the
//   running product and the iteration counter, and tells the top when it
//   needs the ALU.
//   Only instantiated when ACC_SEQ_MUL_EN is defined.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset (counter only)
//   i_start        load mcand/mplier, clear prod and counter
//   i_mcand        multiplicand (accumulator value at accept)
//   i_mplier       multiplier (request operand)
//   i_step_en      one iteration per cycle while high
//   i_alu_o        ALU sum prod+mcand
//   o_alu_req      this iteration needs the ALU (mplier[0] set)
//   o_alu_a/o_alu_b ALU operands for the add
//   o_done         final iteration is in progress this cycle
//   o_prod         product including the current iteration's add
// ---------------------------------------------------------------------------
module acc_mul_step #(
  parameter int WIDTH     = 16,
  parameter int MUL_ITERS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  input  logic             i_step_en,
  input  logic [WIDTH-1:0] i_alu_o,
  output logic             o_alu_req,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);

  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_step_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Operand/product registers are always reloaded by i_start before use
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_prod   <= '0;
    end else if (i_step_en) begin
      if (r_mplier[0]) begin
        r_prod <= i_alu_o;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_alu_req = i_step_en && r_mplier[0];
  assign o_alu_a   = r_prod;
  assign o_alu_b   = r_mcand;
  assign o_done    = i_step_en && (r_cnt == CNT_W'(MUL_ITERS - 1));
  // Lets the top capture the final product on the last iteration's edge
  assign o_prod    = r_mplier[0] ? i_alu_o : r_prod;

endmodule

// File: rtl/acc_alu_sequencer.sv
// ---------------------------------------------------------------------------
// acc_alu_sequencer
//   Control-side driver for the accumulator processor's external
//   combinational ALU. Takes op requests over valid/ready, drives the ALU
//   a/b/s inputs, captures the result into the accumulator (or decodes a
//   compare into flags), and presents a registered response held until
//   accepted.
// Configuration macro
//   ACC_SEQ_MUL_EN  when defined, op 5 (MUL) runs a MUL_ITERS-cycle
//                   shift-add through the ALU; otherwise op 5 is illegal.
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op, req_operand   opcode and b operand / LOAD value
//   alu_a, alu_b, alu_s   drive to external ALU
//   alu_o                 external ALU result
//   rsp_valid/rsp_ready   response handshake
//   rsp_acc               accumulator after the op
//   rsp_flags             {lt,eq,gt}, written only by CMP
//   rsp_err               illegal op or undecodable compare result
// ---------------------------------------------------------------------------
module acc_alu_sequencer
  import acc_alu_sequencer_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MUL_ITERS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_s,
  input  logic [WIDTH-1:0] alu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_acc,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err
);

  if (MUL_ITERS != WIDTH) begin : g_bad_cfg
    $error("acc_alu_sequencer: MUL_ITERS must equal WIDTH");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic [2:0]       r_flags;
  logic             r_rsp_valid;
  logic             r_rsp_err;

  logic             w_accept;
  logic [2:0]       w_cmp_flags;
  logic             w_cmp_err;

  assign w_accept = req_valid && (r_state == ST_IDLE);

`ifdef ACC_SEQ_MUL_EN
  logic             w_mul_start;
  logic             w_mul_step;
  logic             w_mul_req;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_mul_b;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  assign w_mul_start = w_accept && (req_op == OP_MUL);
  assign w_mul_step  = (r_state == ST_MUL);

  acc_mul_step #(
    .WIDTH     (WIDTH),
    .MUL_ITERS (MUL_ITERS)
  ) u_mul_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_mcand   (r_acc),
    .i_mplier  (req_operand),
    .i_step_en (w_mul_step),
    .i_alu_o   (alu_o),
    .o_alu_req (w_mul_req),
    .o_alu_a   (w_mul_a),
    .o_alu_b   (w_mul_b),
    .o_done    (w_mul_done),
    .o_prod    (w_mul_prod)
  );
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_alu_op(req_op)) begin
            w_state_nxt = ST_EXEC;
`ifdef ACC_SEQ_MUL_EN
          end else if (req_op == OP_MUL) begin
            w_state_nxt = ST_MUL;
`endif
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
`ifdef ACC_SEQ_MUL_EN
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_RESP;
`endif
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ALU drive; idle value keeps a=acc so the bus is quiet and predictable
  always_comb begin
    alu_a = r_acc;
    alu_b = '0;
    alu_s = ALU_ADD;
    if (r_state == ST_EXEC) begin
      alu_b = r_operand;
      case (r_op)
        OP_SUB:  alu_s = ALU_SUB;
        OP_SLL:  alu_s = ALU_SLL;
        OP_CMP:  alu_s = ALU_CMP;
        default: alu_s = ALU_ADD;
      endcase
    end
`ifdef ACC_SEQ_MUL_EN
    if (w_mul_req) begin
      alu_a = w_mul_a;
      alu_b = w_mul_b;
      alu_s = ALU_ADD;
    end
`endif
  end

  // Compare decode: any word other than the three legal results is an error
  always_comb begin
    w_cmp_flags = FLAG_NONE;
    w_cmp_err   = 1'b1;
    if (alu_o == WIDTH'(CMP_LT)) begin
      w_cmp_flags = FLAG_LT;
      w_cmp_err   = 1'b0;
    end else if (alu_o == WIDTH'(CMP_EQ)) begin
      w_cmp_flags = FLAG_EQ;
      w_cmp_err   = 1'b0;
    end else if (alu_o == WIDTH'(CMP_GT)) begin
      w_cmp_flags = FLAG_GT;
      w_cmp_err   = 1'b0;
    end
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op      <= req_op;
      r_operand <= req_operand;
    end
  end

  // Accumulator, flags and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_flags     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (req_op == OP_LOAD) begin
              r_acc       <= req_operand;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
            end else if (req_op == OP_CLR) begin
              r_acc       <= '0;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
            end else if (is_alu_op(req_op)) begin
              r_rsp_err   <= 1'b0;
`ifdef ACC_SEQ_MUL_EN
            end else if (req_op == OP_MUL) begin
              r_rsp_err   <= 1'b0;
`endif
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          r_rsp_valid <= 1'b1;
          if (r_op == OP_CMP) begin
            r_flags   <= w_cmp_flags;
            r_rsp_err <= w_cmp_err;
          end else begin
            r_acc     <= alu_o;
            r_rsp_err <= 1'b0;
          end
        end
`ifdef ACC_SEQ_MUL_EN
        ST_MUL: begin
          if (w_mul_done) begin
            r_acc       <= w_mul_prod;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_acc   = r_acc;
  assign rsp_flags = r_flags;
  assign rsp_err   = r_rsp_err;

endmodule
